// File: rtl/rand_fetch_pkg.sv
// rand_fetch_pkg: shared FSM state type and default widths for the random fetch unit
package rand_fetch_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  localparam int DEF_NBITS = 16;
  localparam int DEF_CNTW = 8;
  localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/rand_fetch_fifo.sv
// rand_fetch_fifo: synchronous FIFO with registered storage, head word and occupancy count
module rand_fetch_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               data_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [W-1:0]               head_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign head_o = mem_q[rp_q];
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop = pop_i && !empty_o;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= data_i;
        wp_q <= wp_q + 1'b1;
      end
      if (do_pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/rand_fetch_unit.sv
// rand_fetch_unit: fetches N words from the random engine into a FIFO; RAND_FETCH_DUP_CHECK_EN adds stuck-word detection
module rand_fetch_unit
  import rand_fetch_pkg::*;
#(
  parameter int NBITS = DEF_NBITS,
  parameter int CNTW = DEF_CNTW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [CNTW-1:0]  req_count,
  output logic             eng_go,
  input  logic             eng_done_val,
  input  logic [NBITS-1:0] eng_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_data,
  output logic             busy,
  output logic             err
);
  localparam int AW = $clog2(DEPTH);
  state_e state_q;
  logic [CNTW-1:0] rem_q;
  logic full, empty, fire, push, pop;
  logic [AW:0] cnt;
  assign req_rdy = state_q == IDLE;
  assign fire = req_val && req_rdy;
  assign eng_go = state_q == ISSUE && !full;
  assign push = state_q == WAIT && eng_done_val;
  assign out_val = !empty;
  assign pop = out_val && out_rdy;
  assign busy = state_q != IDLE || cnt != '0;
  // Issue only with free space so the WAIT push can never overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (fire) begin
          rem_q <= req_count;
          state_q <= req_count != '0 ? ISSUE : IDLE;
        end
        ISSUE: if (eng_go) state_q <= WAIT;
        WAIT: if (eng_done_val) begin
          rem_q <= rem_q - 1'b1;
          state_q <= rem_q != CNTW'(1) ? ISSUE : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  rand_fetch_fifo #(.W(NBITS), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(pop),
    .data_i(eng_data),
    .full_o(full),
    .empty_o(empty),
    .count_o(cnt),
    .head_o(out_data)
  );
`ifdef RAND_FETCH_DUP_CHECK_EN
  logic [NBITS-1:0] last_q;
  logic last_v_q, err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
      last_v_q <= 1'b0;
      err_q <= 1'b0;
    end else if (fire) begin
      last_v_q <= 1'b0;
      err_q <= 1'b0;
    end else if (push) begin
      if (last_v_q && eng_data == last_q) err_q <= 1'b1;
      last_q <= eng_data;
      last_v_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_rand_fetch_unit.sv
// tb_rand_fetch_unit: directed scoreboard bench with an engine model and an output monitor
module tb_rand_fetch_unit;
  logic clk = 0, rst = 1, req_val = 0, out_rdy = 0;
  logic [7:0] req_count = '0;
  logic req_rdy, eng_go, eng_done_val, out_val, busy, err;
  logic [15:0] eng_data, out_data;
  logic man = 0, m_val = 0, e_val = 0;
  logic [15:0] m_data = '0, e_data = '0;
  logic [15:0] eng_q[$], exp_q[$];
  int tests = 0, fails = 0, go_cnt = 0, lat = 2, g = 0;

  assign eng_done_val = man ? m_val : e_val;
  assign eng_data = man ? m_data : e_data;

  always #5 clk = ~clk;

  rand_fetch_unit dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_rdy(req_rdy), .req_count(req_count),
    .eng_go(eng_go), .eng_done_val(eng_done_val), .eng_data(eng_data),
    .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data), .busy(busy), .err(err)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // engine: answers each go after lat cycles with the next queued word
  initial begin
    forever begin
      @(negedge clk);
      if (eng_go && !man && !rst) begin
        repeat (lat) @(posedge clk);
        #1;
        e_val = 1;
        e_data = eng_q.size() != 0 ? eng_q.pop_front() : 16'h0;
        @(posedge clk);
        #1;
        e_val = 0;
      end
    end
  end

  // monitor: count go pulses and score every accepted output word
  always @(negedge clk) begin
    if (eng_go) go_cnt++;
    if (out_val && out_rdy) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got %0h with none expected", out_data);
      end else chk("out_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic request(input logic [7:0] n);
    req_val = 1;
    req_count = n;
    @(posedge clk);
    #1;
    req_val = 0;
  endtask

  task automatic queue_word(input logic [15:0] w);
    eng_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_idle(string nm);
    int i = 0;
    while (busy && i < 500) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk({nm, "_idle_timeout"}, i < 500, 1);
  endtask

  task automatic wait_go(int n);
    int i = 0;
    while (go_cnt < n && i < 200) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk("go_timeout", go_cnt >= n, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_eng_go", eng_go, 0);
    chk("rst_out_val", out_val, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 0;
    // basic three-word request
    out_rdy = 1;
    g = go_cnt;
    queue_word(16'hACE1);
    queue_word(16'h5670);
    queue_word(16'h2B38);
    request(3);
    chk("basic_go_at_T1", eng_go, 1);
    chk("basic_req_rdy_low", req_rdy, 0);
    wait_idle("basic");
    chk("basic_go_count", go_cnt - g, 3);
    chk("basic_drained", exp_q.size(), 0);
    chk("basic_req_rdy", req_rdy, 1);
    chk("basic_err", err, 0);
    // backpressure: FIFO fills after four words
    out_rdy = 0;
    g = go_cnt;
    for (int k = 1; k <= 6; k++) queue_word(16'(k * 16'h0101));
    request(6);
    repeat (30) @(posedge clk);
    #1;
    chk("bp_go_count_full", go_cnt - g, 4);
    chk("bp_no_go", eng_go, 0);
    chk("bp_head_stable", out_data, 16'h0101);
    chk("bp_busy", busy, 1);
    out_rdy = 1;
    wait_idle("bp");
    chk("bp_go_count_all", go_cnt - g, 6);
    chk("bp_drained", exp_q.size(), 0);
    // zero count is a no-op
    g = go_cnt;
    request(0);
    chk("zero_busy", busy, 0);
    chk("zero_req_rdy", req_rdy, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("zero_no_go", go_cnt - g, 0);
    chk("zero_busy_late", busy, 0);
    // spurious done in IDLE, held done in WAIT
    man = 1;
    m_val = 1;
    m_data = 16'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    chk("spur_out_val", out_val, 0);
    chk("spur_busy", busy, 0);
    m_val = 0;
    exp_q.push_back(16'h0F0F);
    g = go_cnt;
    request(1);
    chk("held_go", eng_go, 1);
    @(posedge clk);
    #1;
    m_val = 1;
    m_data = 16'h0F0F;
    repeat (3) @(posedge clk);
    #1;
    m_val = 0;
    man = 0;
    wait_idle("held");
    chk("held_go_count", go_cnt - g, 1);
    chk("held_drained", exp_q.size(), 0);
    chk("held_out_val", out_val, 0);
    // reset in WAIT with two words buffered
    out_rdy = 0;
    g = go_cnt;
    queue_word(16'hA001);
    queue_word(16'hA002);
    queue_word(16'hA003);
    queue_word(16'hA004);
    request(4);
    wait_go(g + 3);
    chk("mid_buffered", out_val, 1);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    exp_q.delete();
    chk("mid_out_val", out_val, 0);
    chk("mid_busy", busy, 0);
    chk("mid_req_rdy", req_rdy, 1);
    chk("mid_out_data", out_data, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("mid_late_done_ignored", out_val, 0);
    chk("mid_no_more_go", go_cnt - g, 3);
    chk("mid_busy_late", busy, 0);
    eng_q.delete();
    // duplicate words
    out_rdy = 1;
    queue_word(16'h1234);
    queue_word(16'h1234);
    request(2);
    wait_idle("dup");
`ifdef RAND_FETCH_DUP_CHECK_EN
    chk("dup_err_set", err, 1);
    request(0);
    chk("dup_err_cleared", err, 0);
`else
    chk("dup_err_tied", err, 0);
`endif
    chk("dup_drained", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
